// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control sequencer for a multicycle ARM-subset core.
// Walks each instruction through fetch/decode/execute/writeback, keeps the
// NZCV flags register, evaluates condition codes and drives the datapath
// selects and enables. The instruction and data memory share one port,
// handshaked with mem_req/mem_ready.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   Cond, Op, Funct, Rd           instruction fields from the IR
//   ALUFlags                      NZCV from the ALU in the current cycle
//   mem_ready                     memory finishes the current access
//   mem_req, MemWrite, AdrSrc     memory port control
//   PCWrite, IRWrite, RegWrite    register enables
//   ALUSrcA, ALUSrcB, ALUControl  ALU operand selects and operation
//   ResultSrc, ImmSrc, RegSrc     result, immediate and register-read selects
//   undef                         one-cycle pulse on an unimplemented instruction
//   state                         current state, for debug
module multicycle_ctrl #(
  parameter int FLAG_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  Cond,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rd,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic        undef,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t            cur, nxt;
  logic [FLAG_W-1:0] flags;
  logic              cond_ex, dp_ok, arith;
  logic [1:0]        dp_ctl;
  logic              req_i, pcw_i, irw_i, rw_i, mw_i, undef_i;

  assign state = cur;

  // Immediate and register-read selects only depend on the instruction class.
  assign ImmSrc = (Op == 2'b11) ? 2'b00 : Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

  // Condition evaluation against the stored NZCV.
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags[3:0];
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c && !z;
      4'b1001: cond_ex = !c || z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = !z && (n == v);
      4'b1101: cond_ex = z || (n != v);
      default: cond_ex = 1'b1;  // AL and 1111
    endcase
  end

  // Data-processing opcode decode; anything outside ADD/SUB/AND/ORR is undefined.
  always_comb begin
    dp_ok  = 1'b1;
    dp_ctl = 2'b00;
    case (Funct[4:1])
      4'b0100: dp_ctl = 2'b00;
      4'b0010: dp_ctl = 2'b01;
      4'b0000: dp_ctl = 2'b10;
      4'b1100: dp_ctl = 2'b11;
      default: dp_ok  = 1'b0;
    endcase
  end
  // Only ADD/SUB produce meaningful C and V.
  assign arith = (Funct[4:1] == 4'b0100) || (Funct[4:1] == 4'b0010);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= FETCH;
      flags <= '0;
    end else begin
      cur <= nxt;
      if ((cur == EXECR || cur == EXECI) && Funct[0]) begin
        flags[3:2] <= ALUFlags[3:2];
        if (arith) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    nxt        = FETCH;
    req_i      = 1'b0;
    pcw_i      = 1'b0;
    irw_i      = 1'b0;
    rw_i       = 1'b0;
    mw_i       = 1'b0;
    undef_i    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (cur)
      FETCH: begin
        req_i     = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw_i     = mem_ready;
        pcw_i     = mem_ready;
        nxt       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (cond_ex) begin
          if (Op == 2'b11 || (Op == 2'b00 && !dp_ok)) undef_i = 1'b1;
          else if (Op == 2'b01) nxt = MEMADR;
          else if (Op == 2'b10) nxt = BRANCH;
          else                  nxt = Funct[5] ? EXECI : EXECR;
        end
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        nxt     = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        req_i  = 1'b1;
        AdrSrc = 1'b1;
        nxt    = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rw_i      = 1'b1;
        pcw_i     = (Rd == 4'b1111);
      end
      MEMWR: begin
        req_i  = 1'b1;
        mw_i   = 1'b1;
        AdrSrc = 1'b1;
        nxt    = mem_ready ? FETCH : MEMWR;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (cur == EXECI) ? 2'b01 : 2'b00;
        ALUControl = dp_ctl;
        nxt        = ALUWB;
      end
      ALUWB: begin
        rw_i  = 1'b1;
        pcw_i = (Rd == 4'b1111);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw_i     = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  // Reset forces FETCH, whose decode would otherwise request memory; gate
  // enables with rst_n so nothing is asserted while reset is held.
  assign mem_req  = req_i   & rst_n;
  assign PCWrite  = pcw_i   & rst_n;
  assign IRWrite  = irw_i   & rst_n;
  assign RegWrite = rw_i    & rst_n;
  assign MemWrite = mw_i    & rst_n;
  assign undef    = undef_i & rst_n;

endmodule
